inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 103 ++++++++++
 tb/tb_inst_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request feeding a 2-entry
// {pc, inst} buffer toward the if/id register.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_fifo_pc [2];
  logic [31:0] r_fifo_inst [2];
  logic        r_head, r_tail;
  logic [1:0]  r_count, w_count_nxt;
  logic        w_push, w_pop;

  assign valid_o     = (r_count != 2'd0);
  assign w_pop       = valid_o & ~stall_i;
  assign w_push      = (r_state == WAIT) & imem_ack_i;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign pc_o        = valid_o ? r_fifo_pc[r_head]   : 32'h0000_0000;
  assign inst_o      = valid_o ? r_fifo_inst[r_head] : 32'h0000_0000;

  // A new request is only launched when the buffer will have room for its data.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      IDLE: begin
        if (w_count_nxt < 2'd2) begin
          w_state_nxt = WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
        end else begin
          w_req_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_addr_nxt     = w_fetch_pc_nxt;
          if (w_count_nxt < 2'd2) begin
            w_req_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_fetch_pc     <= 32'h0000_0000;
      r_addr         <= 32'h0000_0000;
      r_req          <= 1'b0;
      r_head         <= 1'b0;
      r_tail         <= 1'b0;
      r_count        <= 2'd0;
      r_fifo_pc[0]   <= 32'h0000_0000;
      r_fifo_pc[1]   <= 32'h0000_0000;
      r_fifo_inst[0] <= 32'h0000_0000;
      r_fifo_inst[1] <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
      r_count    <= w_count_nxt;
      if (w_push) begin
        r_fifo_pc[r_tail]   <= r_addr;
        r_fifo_inst[r_tail] <= imem_data_i;
        r_tail              <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: a memory model acks requests,
// expected {pc, inst} pairs are queued at ack time and popped by a monitor.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int n_checks = 0;
  int n_fails  = 0;
  bit mon_en   = 1'b0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .valid_o     (valid_o),
    .pc_o        (pc_o),
    .inst_o      (inst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Monitor: the buffer head must match the oldest acked-but-unconsumed fetch.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("valid_o", {31'b0, valid_o}, {31'b0, exp_q.size() != 0});
      if (valid_o && exp_q.size() != 0) begin
        chk("pc_o", pc_o, exp_q[0][63:32]);
        chk("inst_o", inst_o, exp_q[0][31:0]);
        if (!stall_i) void'(exp_q.pop_front());
      end else if (!valid_o) begin
        chk("pc_o_idle", pc_o, 32'h0);
        chk("inst_o_idle", inst_o, 32'h0);
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic r, input logic s, input logic a);
    logic        ack_eff;
    logic [31:0] ack_pc;
    logic [31:0] ack_data;
    rst         = r;
    stall_i     = s;
    imem_ack_i  = a;
    imem_data_i = $urandom;
    ack_eff     = a && imem_req_o && !r;
    ack_pc      = exp_pc;
    ack_data    = imem_data_i;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_pc = 32'h0;
      chk("rst_req", {31'b0, imem_req_o}, 32'h0);
      chk("rst_addr", imem_addr_o, 32'h0);
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
    end else begin
      if (ack_eff) begin
        exp_q.push_back({ack_pc, ack_data});
        exp_pc = exp_pc + 32'd4;
      end
      chk("occupancy_le_2", {31'b0, exp_q.size() <= 2}, 32'h1);
      chk("imem_req_o", {31'b0, imem_req_o}, {31'b0, exp_q.size() < 2});
      if (imem_req_o) chk("imem_addr_o", imem_addr_o, exp_pc);
    end
  endtask

  initial begin
    // Reset with stray acks present.
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Full-rate streaming.
    repeat (12) cycle(1'b0, 1'b0, 1'b1);

    // Stalled from reset: buffer fills, request drops, then drains.
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b1);

    // Acks arriving three cycles after each request.
    for (int k = 0; k < 80; k++) cycle(1'b0, 1'b0, (k % 4) == 3);

    // Reset while one entry buffered and a request pending; stray ack in reset.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("pre_rst_count", exp_q.size(), 32'd1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 1'b1);

    // Fetch PC wrap from 0xFFFFFFF8.
    cycle(1'b1, 1'b0, 1'b0);
    force dut.r_fetch_pc = 32'hFFFF_FFF8;
    exp_pc = 32'hFFFF_FFF8;
    cycle(1'b0, 1'b0, 1'b0);
    release dut.r_fetch_pc;
    repeat (8) cycle(1'b0, 1'b0, 1'b1);

    // Stall toggling every cycle with random acks.
    for (int k = 0; k < 300; k++) cycle(1'b0, k[0], 1'($urandom_range(0, 1)));

    // Fully random traffic.
    for (int k = 0; k < 400; k++)
      cycle(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));

    // Drain with no stall so every queued fetch gets compared.
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    chk("drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
